// File: rtl/ram_latency_model_pkg.sv
// Shared state and operation encodings for ram_latency_model.
package RamLatencyModelStates;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } State;

    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } Operation;

endpackage

// File: rtl/memory_interface.sv
// Bus-side memory interface; the RAM model attaches through the slave modport.
interface MemoryInterface #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
);
    logic [ADDRESS_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0]    dataOut;
    logic [DATA_WIDTH-1:0]    dataIn;
    logic                     readEnabled;
    logic                     writeEnabled;
    logic                     functionComplete;

    modport master (
        output address, dataOut, readEnabled, writeEnabled,
        input  dataIn, functionComplete
    );

    modport slave (
        input  address, dataOut, readEnabled, writeEnabled,
        output dataIn, functionComplete
    );
endinterface

// File: rtl/ram_latency_model_storage.sv
// Single-port synchronous word array with registered read data.
module ram_storage #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);
    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clock) begin
        if (wr_en_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/ram_latency_model.sv
// Fixed-latency main-memory model with functionComplete handshake.
// Optional completed-access counters are enabled by defining RAM_ACCESS_COUNTERS_EN.
module ram_latency_model
    import RamLatencyModelStates::*;
#(
    parameter int ADDRESS_WIDTH    = 32,
    parameter int DATA_WIDTH       = 32,
    parameter int MEMORY_DEPTH_LOG = 10,
    parameter int LATENCY          = 4
) (
    input  logic          clock,
    input  logic          reset,
    MemoryInterface.slave ramSlaveInterface
`ifdef RAM_ACCESS_COUNTERS_EN
    ,
    output logic [31:0]   readCount,
    output logic [31:0]   writeCount
`endif
);
    localparam int CW = $clog2(LATENCY + 1);

    State                        state_q, state_d;
    Operation                    op_q, op_d;
    logic [CW-1:0]               cnt_q, cnt_d;
    logic [MEMORY_DEPTH_LOG-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0]       wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]       rdata_q, rdata_d;
    logic                        fc_q, fc_d;
    logic                        mem_we;
    logic [MEMORY_DEPTH_LOG-1:0] mem_addr;
    logic [DATA_WIDTH-1:0]       mem_rdata;
    logic                        req;
    logic                        unused_addr;

    assign req         = ramSlaveInterface.readEnabled | ramSlaveInterface.writeEnabled;
    assign unused_addr = ^ramSlaveInterface.address;

    // While idle the array looks up the bus address so a LATENCY=1 read has its word ready.
    assign mem_addr = (state_q == IDLE) ? ramSlaveInterface.address[MEMORY_DEPTH_LOG-1:0] : addr_q;

    ram_storage #(
        .ADDR_W (MEMORY_DEPTH_LOG),
        .DATA_W (DATA_WIDTH)
    ) u_storage (
        .clock   (clock),
        .wr_en_i (mem_we & ~reset),
        .addr_i  (mem_addr),
        .wdata_i (wdata_q),
        .rdata_o (mem_rdata)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        fc_d    = fc_q;
        mem_we  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    addr_d  = ramSlaveInterface.address[MEMORY_DEPTH_LOG-1:0];
                    wdata_d = ramSlaveInterface.dataOut;
                    op_d    = ramSlaveInterface.writeEnabled ? WRITE : READ;
                    cnt_d   = CW'(LATENCY - 1);
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    if (op_q == WRITE) begin
                        mem_we = 1'b1;
                    end else begin
                        rdata_d = mem_rdata;
                    end
                    fc_d    = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!req) begin
                    fc_d    = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            fc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            fc_q    <= fc_d;
        end
        op_q    <= op_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
    end

    assign ramSlaveInterface.dataIn           = rdata_q;
    assign ramSlaveInterface.functionComplete = fc_q;

`ifdef RAM_ACCESS_COUNTERS_EN
    logic [31:0] rd_cnt_q, wr_cnt_q;
    logic        finishing;

    assign finishing = (state_q == ACCESS) && (cnt_q == '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else if (finishing) begin
            if (op_q == READ && rd_cnt_q != 32'hFFFF_FFFF) begin
                rd_cnt_q <= rd_cnt_q + 32'd1;
            end
            if (op_q == WRITE && wr_cnt_q != 32'hFFFF_FFFF) begin
                wr_cnt_q <= wr_cnt_q + 32'd1;
            end
        end
    end

    assign readCount  = rd_cnt_q;
    assign writeCount = wr_cnt_q;
`endif
endmodule

// File: tb/tb_ram_latency_model.sv
// Bench for ram_latency_model: directed table, corner sequences and randomized traffic.
module tb_ram_latency_model;
    localparam int AW  = 8;
    localparam int DW  = 8;
    localparam int DL  = 4;
    localparam int LAT = 3;

    logic clock;
    logic reset;
    int   vectors;
    int   miscompares;

    logic [DW-1:0] ref_mem [2**DL];
    bit            ref_vld [2**DL];

    MemoryInterface #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

`ifdef RAM_ACCESS_COUNTERS_EN
    logic [31:0] rc, wc;
`endif

    ram_latency_model #(
        .ADDRESS_WIDTH    (AW),
        .DATA_WIDTH       (DW),
        .MEMORY_DEPTH_LOG (DL),
        .LATENCY          (LAT)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .ramSlaveInterface (bus)
`ifdef RAM_ACCESS_COUNTERS_EN
        ,
        .readCount         (rc),
        .writeCount        (wc)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        bit            wr;
        bit            rd;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [DW-1:0] exp;
        int            hold;
    } vec_t;

    vec_t tbl [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic model_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        ref_mem[a % (2**DL)] = d;
        ref_vld[a % (2**DL)] = 1'b1;
    endtask

    // One full handshake; starts and ends just after a falling edge.
    task automatic do_access(input bit wr, input bit rd, input logic [AW-1:0] a,
                             input logic [DW-1:0] d, input int hold, input bit chk,
                             input logic [DW-1:0] expd, input string name);
        int n;
        bit seen;
        bus.address      = a;
        bus.dataOut      = d;
        bus.writeEnabled = wr;
        bus.readEnabled  = rd;
        n    = 0;
        seen = 1'b0;
        while (n < LAT + 6 && !seen) begin
            @(negedge clock);
            n++;
            seen = bus.functionComplete;
        end
        check({name, "_latency"}, 32'(n - 1), 32'(LAT));
        if (wr) model_write(a, d);
        else if (chk) check({name, "_data"}, 32'(bus.dataIn), 32'(expd));
        for (int h = 0; h < hold; h++) begin
            @(negedge clock);
            check({name, "_hold"}, 32'(bus.functionComplete), 32'd1);
        end
        bus.writeEnabled = 1'b0;
        bus.readEnabled  = 1'b0;
        @(negedge clock);
        check({name, "_release"}, 32'(bus.functionComplete), 32'd0);
    endtask

    initial begin
        int highs;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        bit            w;
        vectors     = 0;
        miscompares = 0;
        for (int i = 0; i < 2**DL; i++) ref_vld[i] = 1'b0;
        reset            = 1'b1;
        bus.address      = '0;
        bus.dataOut      = '0;
        bus.readEnabled  = 1'b0;
        bus.writeEnabled = 1'b0;
        repeat (3) @(negedge clock);
        check("reset_fc", 32'(bus.functionComplete), 32'd0);
        check("reset_data", 32'(bus.dataIn), 32'd0);
`ifdef RAM_ACCESS_COUNTERS_EN
        check("reset_rc", rc, 32'd0);
        check("reset_wc", wc, 32'd0);
`endif
        reset = 1'b0;
        @(negedge clock);

        tbl[0] = '{1'b1, 1'b0, 8'h03, 8'hA5, 8'h00, 0};
        tbl[1] = '{1'b0, 1'b1, 8'h03, 8'h00, 8'hA5, 0};
        tbl[2] = '{1'b1, 1'b0, 8'h12, 8'h11, 8'h00, 0};
        tbl[3] = '{1'b0, 1'b1, 8'h02, 8'h00, 8'h11, 0};
        tbl[4] = '{1'b1, 1'b1, 8'h05, 8'h77, 8'h00, 0};
        tbl[5] = '{1'b0, 1'b1, 8'h05, 8'h00, 8'h77, 0};
        tbl[6] = '{1'b0, 1'b1, 8'h03, 8'h00, 8'hA5, 5};
        for (int i = 0; i < 7; i++) begin
            do_access(tbl[i].wr, tbl[i].rd, tbl[i].addr, tbl[i].data, tbl[i].hold,
                      1'b1, tbl[i].exp, $sformatf("tbl%0d", i));
        end

        // Bus inputs change while the access is in flight.
        do_access(1'b1, 1'b0, 8'h09, 8'h5A, 0, 1'b0, 8'h00, "pre9");
        bus.address = 8'h03; bus.dataOut = 8'hC3; bus.writeEnabled = 1'b1;
        @(negedge clock);
        bus.address = 8'h09; bus.dataOut = 8'h99;
        highs = 0;
        while (highs < LAT + 4 && !bus.functionComplete) begin
            @(negedge clock);
            highs++;
        end
        check("latch_done", 32'(bus.functionComplete), 32'd1);
        model_write(8'h03, 8'hC3);
        bus.writeEnabled = 1'b0;
        @(negedge clock);
        do_access(1'b0, 1'b1, 8'h09, 8'h00, 0, 1'b1, 8'h5A, "latch_rd9");
        do_access(1'b0, 1'b1, 8'h03, 8'h00, 0, 1'b1, 8'hC3, "latch_rd3");

        // Request withdrawn mid-access: completes with a single-cycle pulse.
        bus.address = 8'h0A; bus.dataOut = 8'h3C; bus.writeEnabled = 1'b1;
        @(negedge clock);
        bus.writeEnabled = 1'b0;
        highs = 0;
        repeat (LAT + 3) begin
            @(negedge clock);
            if (bus.functionComplete) highs++;
        end
        check("drop_pulse", 32'(highs), 32'd1);
        model_write(8'h0A, 8'h3C);
        do_access(1'b0, 1'b1, 8'h0A, 8'h00, 0, 1'b1, 8'h3C, "drop_rd");

        // Reset one edge into a write aborts it.
        do_access(1'b1, 1'b0, 8'h07, 8'h42, 0, 1'b0, 8'h00, "pre7");
        do_access(1'b0, 1'b1, 8'h07, 8'h00, 0, 1'b1, 8'h42, "pre7_rd");
        bus.address = 8'h07; bus.dataOut = 8'hFF; bus.writeEnabled = 1'b1;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("abort_fc", 32'(bus.functionComplete), 32'd0);
        check("abort_data", 32'(bus.dataIn), 32'd0);
`ifdef RAM_ACCESS_COUNTERS_EN
        check("abort_rc", rc, 32'd0);
        check("abort_wc", wc, 32'd0);
`endif
        reset = 1'b0;
        bus.writeEnabled = 1'b0;
        repeat (LAT + 2) @(negedge clock);
        check("abort_idle_fc", 32'(bus.functionComplete), 32'd0);
        do_access(1'b0, 1'b1, 8'h07, 8'h00, 0, 1'b1, 8'h42, "abort_rd");
        do_access(1'b1, 1'b0, 8'h07, 8'h42, 0, 1'b0, 8'h00, "post_wr");
`ifdef RAM_ACCESS_COUNTERS_EN
        check("count_rc", rc, 32'd1);
        check("count_wc", wc, 32'd1);
`endif

        // Randomized traffic against the reference array.
        for (int i = 0; i < 40; i++) begin
            a = 8'($urandom);
            d = 8'($urandom);
            w = $urandom_range(0, 1) == 1 || !ref_vld[a % (2**DL)];
            do_access(w, !w || ($urandom_range(0, 3) == 0), a, d, $urandom_range(0, 3),
                      1'b1, ref_mem[a % (2**DL)], $sformatf("rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
